// File: rtl/circuit_pack.sv
// Uplink circuit-frame receiver: validates 58-byte type-0x0D frames, stores payload in a ping-pong buffer, serves bits MSB-first.
// Latency: bit_req -> bit_out/bit_out_vld one cycle later; bank swap takes effect on the cycle of the sync edge.
// Backpressure: none; frame_data_vld=0 stalls parsing indefinitely, bit_req past the payload end returns 0 with overrun.
// Ports: sys_clk/rst (sync, active-high); frame_data/_vld + frame_type/frame_len/frame_len_vld (byte stream in);
//        timeslot_in/ldpc_in (period sync); bit_req -> bit_out/bit_out_vld; status pulses frame_err/underrun/overrun.
module circuit_pack #(
    parameter int          CIRCUIT_DATA_LEN = 48,
    parameter int          CIRCUIT_HEAD_LEN = 10,
    parameter logic [7:0]  FRAME_TYPE       = 8'h0D,
    parameter logic [15:0] LINK_ID          = 16'h0001
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic [7:0]  frame_data,
    input  logic        frame_data_vld,
    input  logic [7:0]  frame_type,
    input  logic [15:0] frame_len,
    input  logic        frame_len_vld,
    input  logic [7:0]  timeslot_in,
    input  logic [7:0]  ldpc_in,
    input  logic        bit_req,
    output logic        bit_out,
    output logic        bit_out_vld,
    output logic        rd_bank_valid,
    output logic        frame_err,
    output logic        underrun,
    output logic        overrun
);
    localparam int               FRAME_BYTES   = CIRCUIT_HEAD_LEN + CIRCUIT_DATA_LEN;
    localparam int               PAYLOAD_BITS  = CIRCUIT_DATA_LEN * 8;
    localparam int               PTR_W         = $clog2(PAYLOAD_BITS + 1);
    localparam int               IDX_W         = $clog2(CIRCUIT_DATA_LEN);
    localparam logic [15:0]      FRAME_BYTES16 = 16'(FRAME_BYTES);
    localparam logic [PTR_W-1:0] PTR_END       = PTR_W'(PAYLOAD_BITS);

    typedef enum logic [1:0] {IDLE, HEAD, PAYLOAD, DROP} wr_state_t;

    wr_state_t        state, state_nxt;
    logic [15:0]      byte_cnt;
    logic [15:0]      drop_len;
    logic [15:0]      drop_last;
    logic [1:0]       committed;
    logic             rd_bank;
    logic             wr_bank;
    logic             sync_flag, sync_flag_d1, sync_edge;
    logic             start, start_good, head_bad, last_byte, sync_abort;
    logic             err_set, commit, wr_en, swap;
    logic             rd_bank_eff, rd_valid_eff;
    logic [PTR_W-1:0] ptr, ptr_eff;
    logic [IDX_W-1:0] wr_idx;
    logic [7:0]       rd_byte;
    logic [7:0]       mem [2][CIRCUIT_DATA_LEN];

    assign wr_bank   = ~rd_bank;
    assign sync_flag = (timeslot_in == 8'd0) && (ldpc_in == 8'd0);
    assign sync_edge = sync_flag && !sync_flag_d1;

    // Byte 0 arrives together with frame_len_vld, so its link-id check
    // happens at the start decision rather than in HEAD.
    assign start      = frame_len_vld && frame_data_vld;
    assign start_good = (frame_type == FRAME_TYPE) && (frame_len == FRAME_BYTES16)
                        && (frame_data == LINK_ID[15:8]);
    assign last_byte  = (state == PAYLOAD) && frame_data_vld
                        && (byte_cnt == FRAME_BYTES16 - 16'd1);
    // A frame finishing on the sync cycle is kept; anything else in flight is cut.
    assign sync_abort = sync_edge && ((state == HEAD) || ((state == PAYLOAD) && !last_byte));
    assign drop_last  = (drop_len <= 16'd1) ? 16'd1 : drop_len - 16'd1;
    assign wr_idx     = IDX_W'(byte_cnt - 16'(CIRCUIT_HEAD_LEN));

    always_comb begin
        head_bad = 1'b0;
        case (byte_cnt)
            16'd1:   head_bad = (frame_data != LINK_ID[7:0]);
            16'd8:   head_bad = (frame_data != FRAME_BYTES16[15:8]);
            16'd9:   head_bad = (frame_data != FRAME_BYTES16[7:0]);
            default: head_bad = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge sys_clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state: a new frame start wins over everything, then sync abort.
    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = start_good ? HEAD : DROP;
        end else if (sync_abort) begin
            state_nxt = IDLE;
        end else if (frame_data_vld) begin
            case (state)
                HEAD: begin
                    if (head_bad)
                        state_nxt = DROP;
                    else if (byte_cnt == 16'(CIRCUIT_HEAD_LEN - 1))
                        state_nxt = PAYLOAD;
                end
                PAYLOAD: if (last_byte) state_nxt = IDLE;
                DROP:    if (byte_cnt >= drop_last) state_nxt = IDLE;
                default: state_nxt = state;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        err_set = 1'b0;
        commit  = 1'b0;
        wr_en   = 1'b0;
        if (start) begin
            err_set = (state != IDLE) || !start_good;
        end else if (sync_abort) begin
            err_set = 1'b1;
        end else if (frame_data_vld) begin
            if (state == HEAD)
                err_set = head_bad;
            if (state == PAYLOAD) begin
                wr_en  = 1'b1;
                commit = last_byte;
            end
        end
    end

    // Read side sees the post-swap bank on the sync cycle itself.
    assign swap         = sync_edge && (committed[wr_bank] || commit);
    assign rd_bank_eff  = swap ? wr_bank : rd_bank;
    assign rd_valid_eff = sync_edge ? swap : rd_bank_valid;
    assign ptr_eff      = sync_edge ? '0 : ptr;
    assign rd_byte      = mem[rd_bank_eff][ptr_eff[PTR_W-1:3]];

    always_ff @(posedge sys_clk) begin
        if (wr_en) mem[wr_bank][wr_idx] <= frame_data;
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            byte_cnt      <= '0;
            drop_len      <= '0;
            sync_flag_d1  <= 1'b0;
            committed     <= '0;
            rd_bank       <= 1'b0;
            rd_bank_valid <= 1'b0;
            frame_err     <= 1'b0;
            underrun      <= 1'b0;
            overrun       <= 1'b0;
            ptr           <= '0;
            bit_out       <= 1'b0;
            bit_out_vld   <= 1'b0;
        end else begin
            sync_flag_d1 <= sync_flag;
            frame_err    <= err_set;
            underrun     <= sync_edge && !swap;

            if (start) begin
                byte_cnt <= 16'd1;
                drop_len <= frame_len;
            end else if (frame_data_vld && (state != IDLE)) begin
                byte_cnt <= byte_cnt + 16'd1;
            end

            // Latest commit simply re-sets the flag; the bank data was overwritten in place.
            if (swap) begin
                rd_bank            <= wr_bank;
                committed[wr_bank] <= 1'b0;
            end else if (commit) begin
                committed[wr_bank] <= 1'b1;
            end
            if (sync_edge) rd_bank_valid <= swap;

            bit_out_vld <= bit_req;
            bit_out     <= 1'b0;
            overrun     <= 1'b0;
            ptr         <= ptr_eff;
            if (bit_req) begin
                if (ptr_eff == PTR_END) begin
                    overrun <= 1'b1;
                end else begin
                    bit_out <= rd_valid_eff && rd_byte[3'd7 - ptr_eff[2:0]];
                    ptr     <= ptr_eff + 1'b1;
                end
            end
        end
    end
endmodule
